// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive core.
//   DATA_BITS_DEFAULT : default number of data bits per frame
//   rx_state_e        : receive FSM state encoding
package uart_rx_pkg;

    localparam int unsigned DATA_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRecv,
        StStop,
        StLoad
    } rx_state_e;

endpackage

// File: rtl/sync_falling_edge.sv
// sync_falling_edge: two-flop synchronizer for an asynchronous line plus a
// falling-edge detector on the synchronized value. All flops reset to 1 so an
// idle-high line does not produce a spurious edge out of reset.
// Ports:
//   clk        rising-edge clock
//   n_rst      synchronous active-low reset
//   async_in   asynchronous input line
//   sync_out   synchronized line value
//   fall       1 when previous synchronized value was 1 and current is 0
module sync_falling_edge (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver core. Bit timing comes from an external counter:
// timer_enable runs it, shift_strobe is its rollover. Data is LSB-first.
// Ports:
//   clk            rising-edge clock
//   n_rst          synchronous active-low reset
//   serial_in      asynchronous UART line, idle high
//   shift_strobe   bit-period strobe, honoured in START/RECV/STOP only
//   data_read      consumer took rx_data (one-cycle pulse)
//   timer_enable   bit-period counter enable, decoded from state
//   rx_data        last good received word
//   data_ready     rx_data holds an unread word
//   overrun_error  a good word overwrote an unread word
//   framing_error  last frame had a stop bit of 0
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 shift_strobe,
    input  logic                 data_read,
    output logic                 timer_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error
);

    localparam int unsigned CntW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);

    rx_state_e state_q, state_d;

    logic                 line;
    logic                 start_edge;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 ready_q, ready_d;
    logic                 overrun_q, overrun_d;
    logic                 framing_q, framing_d;

    sync_falling_edge u_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (serial_in),
        .sync_out (line),
        .fall     (start_edge)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_edge) state_d = StStart;
            end
            StStart: begin
                // A high sample means the start edge was a glitch.
                if (shift_strobe) state_d = line ? StIdle : StRecv;
            end
            StRecv: begin
                if (shift_strobe && (count_q == LastBit)) state_d = StStop;
            end
            StStop: begin
                if (shift_strobe) state_d = StLoad;
            end
            StLoad: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        timer_enable = 1'b0;
        unique case (state_q)
            StStart, StRecv, StStop: timer_enable = 1'b1;
            default:                 timer_enable = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        shift_d   = shift_q;
        count_d   = count_q;
        stop_d    = stop_q;
        rx_data_d = rx_data_q;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        framing_d = framing_q;

        if (data_read) begin
            ready_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    count_d   = '0;
                    framing_d = 1'b0;
                end
            end
            StRecv: begin
                if (shift_strobe) begin
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    count_d = count_q + 1'b1;
                end
            end
            StStop: begin
                if (shift_strobe) stop_d = line;
            end
            StLoad: begin
                if (stop_q) begin
                    // A load beats a same-cycle read; overrun only if unread.
                    rx_data_d = shift_q;
                    ready_d   = 1'b1;
                    if (ready_q && !data_read) overrun_d = 1'b1;
                end else begin
                    framing_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            shift_q   <= '0;
            count_q   <= '0;
            stop_q    <= 1'b0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            count_q   <= count_d;
            stop_q    <= stop_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            framing_q <= framing_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign data_ready    = ready_q;
    assign overrun_error = overrun_q;
    assign framing_error = framing_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core (DATA_BITS=8).
module tb_uart_rx_core;

    logic       clk;
    logic       n_rst;
    logic       serial_in;
    logic       shift_strobe;
    logic       data_read;
    logic       timer_enable;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       overrun_error;
    logic       framing_error;

    int errors = 0;
    int checks = 0;

    uart_rx_core #(
        .DATA_BITS (8)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .shift_strobe  (shift_strobe),
        .data_read     (data_read),
        .timer_enable  (timer_enable),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold a bit on the line long enough to pass the synchronizer, then strobe.
    task automatic strobe_bit(input logic b);
        serial_in = b;
        repeat (3) tick();
        shift_strobe = 1'b1;
        tick();
        shift_strobe = 1'b0;
    endtask

    // Idle high, drop the line, wait for START, strobe the start bit.
    task automatic start_frame();
        serial_in = 1'b1;
        repeat (4) tick();
        serial_in = 1'b0;
        repeat (4) tick();
        strobe_bit(1'b0);
    endtask

    // Full frame; data_read is driven during the LOAD cycle from rd_in_load.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_in_load);
        start_frame();
        for (int i = 0; i < 8; i++) strobe_bit(d[i]);
        strobe_bit(stop);
        check("load_timer_enable", timer_enable, 0);
        data_read = rd_in_load;
        tick();
        data_read = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
    endtask

    initial begin
        n_rst        = 1'b0;
        serial_in    = 1'b1;
        shift_strobe = 1'b0;
        data_read    = 1'b0;
        repeat (2) tick();

        check("rst_rx_data", rx_data, 0);
        check("rst_data_ready", data_ready, 0);
        check("rst_overrun", overrun_error, 0);
        check("rst_framing", framing_error, 0);
        check("rst_timer_enable", timer_enable, 0);
        n_rst = 1'b1;

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1, 1'b0);
        check("a5_rx_data", rx_data, 8'hA5);
        check("a5_data_ready", data_ready, 1);
        check("a5_overrun", overrun_error, 0);
        check("a5_framing", framing_error, 0);
        pulse_read();
        check("a5_read_ready", data_ready, 0);

        // Overrun: 0x3C unread, then 0xC3
        send_frame(8'h3C, 1'b1, 1'b0);
        check("3c_rx_data", rx_data, 8'h3C);
        check("3c_overrun", overrun_error, 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        check("c3_rx_data", rx_data, 8'hC3);
        check("c3_data_ready", data_ready, 1);
        check("c3_overrun", overrun_error, 1);
        pulse_read();
        check("c3_read_ready", data_ready, 0);
        check("c3_read_overrun", overrun_error, 0);

        // Framing error: 0x55 with stop=0
        send_frame(8'h55, 1'b0, 1'b0);
        check("55_framing", framing_error, 1);
        check("55_data_ready", data_ready, 0);
        check("55_rx_data", rx_data, 8'hC3);
        check("55_overrun", overrun_error, 0);

        // Next start edge clears framing_error; line returns high before the
        // start strobe, so the frame is abandoned as a glitch.
        serial_in = 1'b1;
        repeat (4) tick();
        serial_in = 1'b0;
        repeat (4) tick();
        check("edge_framing_clear", framing_error, 0);
        check("start_timer_enable", timer_enable, 1);
        serial_in = 1'b1;
        repeat (3) tick();
        shift_strobe = 1'b1;
        tick();
        shift_strobe = 1'b0;
        check("glitch_timer_enable", timer_enable, 0);
        check("glitch_framing", framing_error, 0);
        check("glitch_data_ready", data_ready, 0);
        check("glitch_rx_data", rx_data, 8'hC3);

        // Load flags before reset test: ready from 0x5A, framing from 0x66/stop=0
        send_frame(8'h5A, 1'b1, 1'b0);
        check("5a_rx_data", rx_data, 8'h5A);
        send_frame(8'h66, 1'b0, 1'b0);
        check("66_framing", framing_error, 1);
        check("66_data_ready", data_ready, 1);

        // Reset after 4 data bits of 0xFF
        start_frame();
        for (int i = 0; i < 4; i++) strobe_bit(1'b1);
        n_rst = 1'b0;
        repeat (2) tick();
        check("midrst_rx_data", rx_data, 0);
        check("midrst_data_ready", data_ready, 0);
        check("midrst_overrun", overrun_error, 0);
        check("midrst_framing", framing_error, 0);
        check("midrst_timer_enable", timer_enable, 0);
        n_rst = 1'b1;
        send_frame(8'h81, 1'b1, 1'b0);
        check("81_rx_data", rx_data, 8'h81);
        check("81_data_ready", data_ready, 1);
        check("81_overrun", overrun_error, 0);

        // Read in the LOAD cycle of 0x12 while data_ready=1: load wins
        send_frame(8'h12, 1'b1, 1'b1);
        check("12_rx_data", rx_data, 8'h12);
        check("12_data_ready", data_ready, 1);
        check("12_overrun", overrun_error, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
